// File: rtl/if_fetch_redirect_if.sv
// Bundle of the fetch stage's pipeline-control, instruction-memory and IF/ID
// signals. The master side is the fetch stage.
interface if_fetch_redirect_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rdy;
  logic [15:0]       imem_rdata;
  logic              ifid_valid;
  logic [15:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;

  modport master (
    input  stall, br_valid, br_taken, br_target, imem_rdy, imem_rdata,
    output imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

  modport slave (
    output stall, br_valid, br_taken, br_target, imem_rdy, imem_rdata,
    input  imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );
endinterface

// File: rtl/if_fetch_redirect.sv
// Instruction-fetch stage: drives the req/rdy memory port, fills IF/ID, applies
// taken-branch redirects from ID, and absorbs one completed fetch during a stall.
module if_fetch_redirect #(
  parameter int unsigned      ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned      PC_INC   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  if_fetch_redirect_if.master bus
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic              pending_q, pending_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [15:0]       ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [15:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;

  logic req;
  logic done;
  logic redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      redir_pc_q   <= '0;
      pending_q    <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      buf_q        <= '0;
      buf_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pc_q   <= redir_pc_d;
      pending_q    <= pending_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      buf_q        <= buf_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pc_d   = redir_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    buf_d        = buf_q;
    buf_pc_d     = buf_pc_q;
    req          = 1'b0;
    done         = 1'b0;
    redirect     = bus.br_valid & bus.br_taken & ~bus.stall;

    unique case (state_q)
      FETCH: begin
        req  = ~bus.stall | pending_q;
        done = req & bus.imem_rdy;
        if (redirect) begin
          ifid_valid_d = 1'b0;
          // An unfinished request must keep its address on the bus, so the
          // target is parked in redir_pc until the stale beat drains.
          if (!done) begin
            redir_pc_d = bus.br_target;
            state_d    = DISCARD;
          end else begin
            fetch_pc_d = bus.br_target;
          end
        end else if (bus.stall) begin
          if (done) begin
            buf_d      = bus.imem_rdata;
            buf_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + INC;
            state_d    = HOLD;
          end
        end else if (done) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = bus.imem_rdata;
          ifid_pc_d    = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + INC;
        end else begin
          ifid_valid_d = 1'b0;
        end
      end

      DISCARD: begin
        req = 1'b1;
        if (bus.imem_rdy) begin
          fetch_pc_d = redir_pc_q;
          state_d    = FETCH;
        end
      end

      HOLD: begin
        if (!bus.stall) begin
          state_d = FETCH;
          if (redirect) begin
            fetch_pc_d   = bus.br_target;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = buf_q;
            ifid_pc_d    = buf_pc_q;
          end
        end
      end

      default: state_d = FETCH;
    endcase

    pending_d = req & ~bus.imem_rdy;
  end

  assign bus.imem_req   = req & rst_n;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed plus randomized bench for if_fetch_redirect, checked cycle by cycle
// against a transaction-level model of the fetch stage.
module tb_if_fetch_redirect;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_redirect_if #(.ADDR_W(16)) bus ();
  if_fetch_redirect_if #(.ADDR_W(16)) bus2 ();

  if_fetch_redirect #(.ADDR_W(16), .RESET_PC(16'h0000), .PC_INC(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  if_fetch_redirect #(.ADDR_W(16), .RESET_PC(16'hFFFC), .PC_INC(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master)
  );

  int checks = 0;
  int failures = 0;
  bit addr_data = 1'b0;

  // Model: the next address to fetch, the visible IF/ID contents, and flags for
  // "a stale beat is being drained" and "one word is parked during a stall".
  logic [15:0] m_pc, m_redir, m_buf, m_buf_pc, m_instr, m_ifpc;
  bit          m_valid, m_discard, m_hold, m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_pc = 16'h0000; m_redir = '0; m_buf = '0; m_buf_pc = '0;
    m_instr = '0; m_ifpc = '0;
    m_valid = 0; m_discard = 0; m_hold = 0; m_out = 0;
  endtask

  task automatic tick(input string tag);
    bit req, done, redirect, taken;
    #1;
    if (addr_data) bus.imem_rdata = bus.imem_addr ^ 16'h5A3C;
    #1;
    req = m_discard ? 1'b1 : (m_hold ? 1'b0 : (!bus.stall || m_out));
    chk({tag, ":req"},   {31'b0, bus.imem_req},   {31'b0, req});
    chk({tag, ":addr"},  {16'b0, bus.imem_addr},  {16'b0, m_pc});
    chk({tag, ":valid"}, {31'b0, bus.ifid_valid}, {31'b0, m_valid});
    chk({tag, ":instr"}, {16'b0, bus.ifid_instr}, {16'b0, m_instr});
    chk({tag, ":ifpc"},  {16'b0, bus.ifid_pc},    {16'b0, m_ifpc});

    taken    = bus.br_valid && bus.br_taken;
    redirect = taken && !bus.stall;
    done     = req && bus.imem_rdy;
    if (m_discard) begin
      if (bus.imem_rdy) begin
        m_discard = 0;
        m_pc = m_redir;
      end
    end else if (m_hold) begin
      if (!bus.stall) begin
        m_hold = 0;
        if (taken) begin
          m_pc = bus.br_target;
          m_valid = 0;
        end else begin
          m_valid = 1; m_instr = m_buf; m_ifpc = m_buf_pc;
        end
      end
    end else if (redirect) begin
      m_valid = 0;
      if (done) m_pc = bus.br_target;
      else begin
        m_discard = 1;
        m_redir = bus.br_target;
      end
    end else if (bus.stall) begin
      if (done) begin
        m_hold = 1; m_buf = bus.imem_rdata; m_buf_pc = m_pc; m_pc = m_pc + 16'd2;
      end
    end else if (done) begin
      m_valid = 1; m_instr = bus.imem_rdata; m_ifpc = m_pc; m_pc = m_pc + 16'd2;
    end else begin
      m_valid = 0;
    end
    m_out = req && !bus.imem_rdy;

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.br_valid = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.imem_rdy = 0; bus.imem_rdata = '0;
    bus2.stall = 0; bus2.br_valid = 0; bus2.br_taken = 0; bus2.br_target = '0;
    bus2.imem_rdy = 1; bus2.imem_rdata = 16'h1234;
    mreset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst:req",   {31'b0, bus.imem_req},   32'd0);
    chk("rst:valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("rst:ifpc",  {16'b0, bus.ifid_pc},    32'd0);
    chk("rst:instr", {16'b0, bus.ifid_instr}, 32'd0);
    chk("rst:wrap_req", {31'b0, bus2.imem_req}, 32'd0);

    rst_n = 1'b1;
    bus.imem_rdy = 1; addr_data = 1;
    #1;
    chk("rel:req",  {31'b0, bus.imem_req},   32'd1);
    chk("wrap0",    {16'b0, bus2.imem_addr}, 32'h0000FFFC);

    tick("seq0");
    chk("seq0:ifpc",  {16'b0, bus.ifid_pc},    32'h0);
    chk("seq0:valid", {31'b0, bus.ifid_valid}, 32'd1);
    chk("wrap1",      {16'b0, bus2.imem_addr}, 32'h0000FFFE);

    bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 16'h0004;
    tick("redir_done");
    chk("redir_done:addr",  {16'b0, bus.imem_addr},  32'h4);
    chk("redir_done:valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("wrap2",            {16'b0, bus2.imem_addr}, 32'h0);

    bus.br_taken = 0; bus.br_target = 16'h0010;
    tick("not_taken");
    bus.br_valid = 0;
    chk("not_taken:ifpc", {16'b0, bus.ifid_pc},    32'h4);
    chk("not_taken:addr", {16'b0, bus.imem_addr},  32'h6);
    chk("wrap3",          {16'b0, bus2.imem_addr}, 32'h2);

    bus.imem_rdy = 0; bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 16'h0040;
    tick("redir_pend");
    bus.br_target = 16'h0099; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("discard_wait");
      chk("discard:addr",  {16'b0, bus.imem_addr},  32'h6);
      chk("discard:valid", {31'b0, bus.ifid_valid}, 32'd0);
    end
    bus.br_valid = 0; bus.stall = 0; bus.imem_rdy = 1;
    tick("discard_drop");
    chk("drop:addr",  {16'b0, bus.imem_addr},  32'h40);
    chk("drop:valid", {31'b0, bus.ifid_valid}, 32'd0);
    tick("seq40");

    bus.stall = 1;
    tick("stall_done");
    for (int i = 0; i < 2; i++) begin
      chk("hold:req",  {31'b0, bus.imem_req}, 32'd0);
      chk("hold:ifpc", {16'b0, bus.ifid_pc},  32'h40);
      tick("hold");
    end
    bus.stall = 0;
    tick("unstall");
    chk("unstall:ifpc",  {16'b0, bus.ifid_pc},    32'h42);
    chk("unstall:instr", {16'b0, bus.ifid_instr}, 32'h42 ^ 32'h5A3C);
    chk("unstall:addr",  {16'b0, bus.imem_addr},  32'h44);

    bus.stall = 1;
    tick("stall_done2");
    bus.stall = 0; bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 16'h0080;
    tick("unstall_redir");
    bus.br_valid = 0;
    chk("unstall_redir:valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("unstall_redir:addr",  {16'b0, bus.imem_addr},  32'h80);

    bus.imem_rdy = 0;
    tick("pend0");
    bus.stall = 1;
    tick("stall_pending");
    bus.imem_rdy = 1;
    tick("stall_pending_done");
    bus.stall = 0;
    tick("after_pending");

    bus.imem_rdy = 0; bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 16'h0200;
    tick("redir_pend2");
    bus.br_valid = 0;
    tick("discard_wait2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst:req",   {31'b0, bus.imem_req},   32'd0);
    chk("midrst:valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("midrst:addr",  {16'b0, bus.imem_addr},  32'h0);
    chk("midrst:ifpc",  {16'b0, bus.ifid_pc},    32'h0);
    @(posedge clk);
    #1;
    mreset();
    bus.imem_rdy = 1;
    rst_n = 1'b1;
    #1;
    chk("rel2:req",  {31'b0, bus.imem_req},  32'd1);
    chk("rel2:addr", {16'b0, bus.imem_addr}, 32'h0);
    tick("after_reset");
    chk("after_reset:ifpc",  {16'b0, bus.ifid_pc},    32'h0);
    chk("after_reset:valid", {31'b0, bus.ifid_valid}, 32'd1);

    addr_data = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.stall      = ($urandom % 4) == 0;
      bus.imem_rdy   = ($urandom % 3) != 0;
      bus.br_valid   = ($urandom % 4) == 0;
      bus.br_taken   = $urandom % 2;
      bus.br_target  = 16'($urandom) & 16'hFFFE;
      bus.imem_rdata = 16'($urandom);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
